caliptra_fpga_sync_run_ctrl: RTL and testbench
==============================================

Name: caliptra_fpga_sync_run_ctrl

Overview:
- Run controller for the gated core clock on the FPGA sync bridge.
- Converts host "go" commands into an exact budget of enabled clock cycles and halts early on breakpoint events (level or change-detected) or a host stop.
- Reports the remaining budget, the halt cause and sticky per-event breakpoint status back to the register block.
- Its gate_en output is the enable that the top level ANDs with aclk to produce the core clock. Sits between the register block and that clock gate.

Parameters:
NUM_EVT, 4, number of breakpoint event inputs
CNT_W, 32, width of cycle budget and remaining counter

Ports:
aclk  input  1  free-running clock; all logic is posedge aclk
rstn  input  1  reset, synchronous, active-low
go  input  1  single-cycle start request
cycle_count  input  CNT_W  budget of gated cycles, sampled with go
stop  input  1  single-cycle host halt request
evt_i  input  NUM_EVT  event levels from the core domain
evt_edge_mode  input  NUM_EVT  per event: 1 = fire on change, 0 = fire on high level
bkpt_en  input  NUM_EVT  per-event breakpoint enable
bkpt_clr  input  NUM_EVT  write-1-to-clear pulses for bkpt_status
gate_en  output  1  clock enable for the gated domain (registered)
running  output  1  high in RUN state
remaining  output  CNT_W  gated cycles left in the current run
bkpt_status  output  NUM_EVT  sticky breakpoint-hit flags
halt_cause  output  2  0 = none, 1 = budget, 2 = breakpoint, 3 = stop
done  output  1  one-cycle pulse when a run ends

Behaviour:
- Reset (rstn=0 at a posedge):
  - gate_en=0, running=0, remaining=0, bkpt_status=0, halt_cause=0, done=0.
  - evt_prev=0; state=IDLE.
  - Reset applies mid-run too: gate_en drops at that edge.
- States are IDLE and RUN. gate_en==running; both are registered state outputs.
- IDLE:
  - go=1, stop=0, cycle_count>0: next cycle RUN, remaining=cycle_count, halt_cause=0, evt_prev=evt_i.
  - go=1, cycle_count==0: stay IDLE, done pulses next cycle, halt_cause=1.
  - go=1 with stop=1: stop wins, no start.
- Gated cycle: any cycle with gate_en=1. A run of N with no halt yields exactly N gated cycles.
- RUN, each cycle:
  - remaining decrements by 1.
  - evt_prev captures evt_i.
  - fire[i] = (evt_edge_mode[i] ? evt_i[i]!=evt_prev[i] : evt_i[i]).
  - hit[i] = bkpt_en[i] & fire[i] & ~bkpt_status[i].
- RUN exit on the same edge as the triggering cycle, with gate_en=0 at the next edge. Priority: stop > any hit > remaining==1. Cause is recorded accordingly as 3 / 2 / 1.
  - All hit bits set bkpt_status regardless of which cause wins.
  - remaining still decrements for the exiting cycle. Early halt leaves remaining = budget minus gated cycles consumed.
- done pulses for one cycle on the first cycle gate_en=0 after a RUN. halt_cause holds until the next accepted go.
- go while in RUN is ignored. stop in IDLE is ignored.
- bkpt_status:
  - Set only in RUN.
  - Cleared by bkpt_clr; set beats clear in the same cycle.
  - A set bit masks its own event, so a re-go resumes past a still-asserted level event.
- evt_prev updates only on gated cycles, so change detection compares consecutive core cycles.
- No wrap: remaining never decrements below 0.

Test Plan:
- go with cycle_count=5, no events -> gate_en high exactly 5 aclk cycles; remaining 5,4,3,2,1,0; done one cycle later; halt_cause=1.
- bkpt_en=4'b0001, level mode, evt_i[0] rises on the 3rd gated cycle of a 10-cycle run -> 3 gated cycles total; remaining=7; bkpt_status=4'b0001; halt_cause=2.
  - Follow with re-go of 4 while evt_i[0] is still high -> 4 gated cycles, halt_cause=1.
- Edge mode on evt 2, evt_i[2] toggles 0->1 on gated cycle 2 of 8 -> halt after cycle 2, remaining=6.
  - With evt_i[2] held constant, re-go of 3 (after clearing the status bit) -> no hit, 3 cycles.
- stop and evt hit in the same cycle of a 20-cycle run -> halt_cause=3; bkpt_status bit still set.
  - bkpt_clr pulsed in the same cycle as a new set -> bit stays 1.
- go with cycle_count=0 -> gate_en never rises; done pulses; halt_cause=1.
  - go during RUN -> remaining unaffected.
- rstn low for one cycle at gated cycle 4 of a 100-cycle run -> next cycle gate_en=0, remaining=0, bkpt_status=0, halt_cause=0, no done pulse.

Source files
------------

// File: rtl/caliptra_fpga_sync_run_ctrl.sv
// caliptra_fpga_sync_run_ctrl
// Run controller for the gated core clock on the FPGA sync bridge. A host
// "go" grants an exact budget of enabled core cycles. A host stop or a
// breakpoint event cuts the run short. Remaining budget, halt cause and
// sticky breakpoint flags are reported back to the register block.
module caliptra_fpga_sync_run_ctrl #(
  parameter int NUM_EVT = 4,
  parameter int CNT_W   = 32
) (
  input  logic               aclk,
  input  logic               rstn,
  input  logic               go,
  input  logic [CNT_W-1:0]   cycle_count,
  input  logic               stop,
  input  logic [NUM_EVT-1:0] evt_i,
  input  logic [NUM_EVT-1:0] evt_edge_mode,
  input  logic [NUM_EVT-1:0] bkpt_en,
  input  logic [NUM_EVT-1:0] bkpt_clr,
  output logic               gate_en,
  output logic               running,
  output logic [CNT_W-1:0]   remaining,
  output logic [NUM_EVT-1:0] bkpt_status,
  output logic [1:0]         halt_cause,
  output logic               done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [1:0] CAUSE_NONE   = 2'd0;
  localparam logic [1:0] CAUSE_BUDGET = 2'd1;
  localparam logic [1:0] CAUSE_BKPT   = 2'd2;
  localparam logic [1:0] CAUSE_STOP   = 2'd3;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   remaining_q, remaining_d;
  logic [NUM_EVT-1:0] evt_prev_q, evt_prev_d;
  logic [NUM_EVT-1:0] status_q, status_d;
  logic [1:0]         cause_q, cause_d;
  logic               done_q, done_d;
  logic [NUM_EVT-1:0] fire;
  logic [NUM_EVT-1:0] hit;

  // Breakpoint detection; only gated cycles can hit, and a bit already set masks its own event.
  always_comb begin
    fire = (evt_edge_mode & (evt_i ^ evt_prev_q)) | (~evt_edge_mode & evt_i);
    hit  = '0;
    if (state_q == RUN) begin
      hit = bkpt_en & fire & ~status_q;
    end
  end

  // Next-state logic: start/refuse in IDLE, count down and pick the halt cause in RUN.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    evt_prev_d  = evt_prev_q;
    cause_d     = cause_q;
    done_d      = 1'b0;
    status_d    = (status_q & ~bkpt_clr) | hit;

    unique case (state_q)
      IDLE: begin
        if (go && !stop) begin
          if (cycle_count != '0) begin
            state_d     = RUN;
            remaining_d = cycle_count;
            cause_d     = CAUSE_NONE;
            evt_prev_d  = evt_i;
          end else begin
            done_d  = 1'b1;
            cause_d = CAUSE_BUDGET;
          end
        end
      end
      RUN: begin
        evt_prev_d = evt_i;
        if (remaining_q != '0) begin
          remaining_d = remaining_q - CNT_W'(1);
        end
        if (stop) begin
          state_d = IDLE;
          done_d  = 1'b1;
          cause_d = CAUSE_STOP;
        end else if (|hit) begin
          state_d = IDLE;
          done_d  = 1'b1;
          cause_d = CAUSE_BKPT;
        end else if (remaining_q <= CNT_W'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
          cause_d = CAUSE_BUDGET;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and status registers; reset also kills a run in progress.
  always_ff @(posedge aclk) begin
    if (!rstn) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      evt_prev_q  <= '0;
      status_q    <= '0;
      cause_q     <= CAUSE_NONE;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      evt_prev_q  <= evt_prev_d;
      status_q    <= status_d;
      cause_q     <= cause_d;
      done_q      <= done_d;
    end
  end

  assign gate_en     = (state_q == RUN);
  assign running     = (state_q == RUN);
  assign remaining   = remaining_q;
  assign bkpt_status = status_q;
  assign halt_cause  = cause_q;
  assign done        = done_q;

endmodule

// File: tb/tb_caliptra_fpga_sync_run_ctrl.sv
// Directed bench for caliptra_fpga_sync_run_ctrl. Each driven step pushes the
// output values expected after the next aclk edge; they are popped and
// compared #1 after that edge.
module tb_caliptra_fpga_sync_run_ctrl;

  logic        aclk;
  logic        rstn;
  logic        go;
  logic [31:0] cycle_count;
  logic        stop;
  logic [3:0]  evt_i;
  logic [3:0]  evt_edge_mode;
  logic [3:0]  bkpt_en;
  logic [3:0]  bkpt_clr;
  logic        gate_en;
  logic        running;
  logic [31:0] remaining;
  logic [3:0]  bkpt_status;
  logic [1:0]  halt_cause;
  logic        done;

  typedef struct {
    logic        gate;
    logic [31:0] rem;
    logic        dn;
    logic [1:0]  cause;
    logic [3:0]  status;
  } exp_t;

  exp_t expQ[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   stepNum     = 0;

  caliptra_fpga_sync_run_ctrl #(
    .NUM_EVT(4),
    .CNT_W  (32)
  ) dut (
    .aclk         (aclk),
    .rstn         (rstn),
    .go           (go),
    .cycle_count  (cycle_count),
    .stop         (stop),
    .evt_i        (evt_i),
    .evt_edge_mode(evt_edge_mode),
    .bkpt_en      (bkpt_en),
    .bkpt_clr     (bkpt_clr),
    .gate_en      (gate_en),
    .running      (running),
    .remaining    (remaining),
    .bkpt_status  (bkpt_status),
    .halt_cause   (halt_cause),
    .done         (done)
  );

  // Free-running clock
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic pushExp(input logic g, input logic [31:0] r, input logic d,
                         input logic [1:0] c, input logic [3:0] s);
    exp_t e;
    e.gate   = g;
    e.rem    = r;
    e.dn     = d;
    e.cause  = c;
    e.status = s;
    expQ.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      vectors++;
      assert (gate_en === e.gate) else begin
        miscompares++;
        $error("[TB] FAIL step%0d gate_en observed=%0b expected=%0b", stepNum, gate_en, e.gate);
      end
      vectors++;
      assert (running === e.gate) else begin
        miscompares++;
        $error("[TB] FAIL step%0d running observed=%0b expected=%0b", stepNum, running, e.gate);
      end
      vectors++;
      assert (remaining === e.rem) else begin
        miscompares++;
        $error("[TB] FAIL step%0d remaining observed=%0d expected=%0d", stepNum, remaining, e.rem);
      end
      vectors++;
      assert (done === e.dn) else begin
        miscompares++;
        $error("[TB] FAIL step%0d done observed=%0b expected=%0b", stepNum, done, e.dn);
      end
      vectors++;
      assert (halt_cause === e.cause) else begin
        miscompares++;
        $error("[TB] FAIL step%0d halt_cause observed=%0d expected=%0d", stepNum, halt_cause, e.cause);
      end
      vectors++;
      assert (bkpt_status === e.status) else begin
        miscompares++;
        $error("[TB] FAIL step%0d bkpt_status observed=%b expected=%b", stepNum, bkpt_status, e.status);
      end
    end
  endtask

  task automatic applyStimulus(input logic g, input logic [31:0] cnt, input logic s,
                               input logic [3:0] ev, input logic [3:0] clr, input logic rn);
    go          = g;
    cycle_count = cnt;
    stop        = s;
    evt_i       = ev;
    bkpt_clr    = clr;
    rstn        = rn;
    @(posedge aclk);
    #1;
    stepNum++;
    checkOutput();
  endtask

  task automatic idleStep(input logic [3:0] ev);
    applyStimulus(1'b0, 32'd0, 1'b0, ev, 4'b0000, 1'b1);
  endtask

  // Directed sequence covering budget runs, breakpoints, stop, zero budget and reset
  initial begin
    evt_edge_mode = 4'b0000;
    bkpt_en       = 4'b0000;

    // Reset state
    pushExp(0, 0, 0, 0, 4'b0000); applyStimulus(0, 0, 0, 4'b0000, 4'b0000, 0);
    pushExp(0, 0, 0, 0, 4'b0000); applyStimulus(0, 0, 0, 4'b0000, 4'b0000, 0);

    // Budget of 5, no events
    pushExp(1, 5, 0, 0, 4'b0000); applyStimulus(1, 5, 0, 4'b0000, 4'b0000, 1);
    for (int r = 4; r >= 1; r--) begin
      pushExp(1, 32'(r), 0, 0, 4'b0000); idleStep(4'b0000);
    end
    pushExp(0, 0, 1, 1, 4'b0000); idleStep(4'b0000);
    pushExp(0, 0, 0, 1, 4'b0000); idleStep(4'b0000);

    // Level breakpoint on evt 0 at gated cycle 3 of 10
    bkpt_en = 4'b0001;
    pushExp(1, 10, 0, 0, 4'b0000); applyStimulus(1, 10, 0, 4'b0000, 4'b0000, 1);
    pushExp(1, 9, 0, 0, 4'b0000);  idleStep(4'b0000);
    pushExp(1, 8, 0, 0, 4'b0000);  idleStep(4'b0000);
    pushExp(0, 7, 1, 2, 4'b0001);  idleStep(4'b0001);
    pushExp(0, 7, 0, 2, 4'b0001);  idleStep(4'b0001);
    // Re-go of 4 with the level still high: masked by the sticky bit
    pushExp(1, 4, 0, 0, 4'b0001);  applyStimulus(1, 4, 0, 4'b0001, 4'b0000, 1);
    for (int r = 3; r >= 1; r--) begin
      pushExp(1, 32'(r), 0, 0, 4'b0001); idleStep(4'b0001);
    end
    pushExp(0, 0, 1, 1, 4'b0001);  idleStep(4'b0001);
    pushExp(0, 0, 0, 1, 4'b0000);  applyStimulus(0, 0, 0, 4'b0000, 4'b0001, 1);

    // Edge breakpoint on evt 2 at gated cycle 2 of 8
    bkpt_en       = 4'b0100;
    evt_edge_mode = 4'b0100;
    pushExp(1, 8, 0, 0, 4'b0000);  applyStimulus(1, 8, 0, 4'b0000, 4'b0000, 1);
    pushExp(1, 7, 0, 0, 4'b0000);  idleStep(4'b0000);
    pushExp(0, 6, 1, 2, 4'b0100);  idleStep(4'b0100);
    pushExp(0, 6, 0, 2, 4'b0100);  idleStep(4'b0100);
    pushExp(0, 6, 0, 2, 4'b0000);  applyStimulus(0, 0, 0, 4'b0100, 4'b0100, 1);
    // Constant high level in edge mode: no hit
    pushExp(1, 3, 0, 0, 4'b0000);  applyStimulus(1, 3, 0, 4'b0100, 4'b0000, 1);
    pushExp(1, 2, 0, 0, 4'b0000);  idleStep(4'b0100);
    pushExp(1, 1, 0, 0, 4'b0000);  idleStep(4'b0100);
    pushExp(0, 0, 1, 1, 4'b0000);  idleStep(4'b0100);

    // Stop and a hit in the same cycle of a 20-cycle run
    bkpt_en       = 4'b0010;
    evt_edge_mode = 4'b0000;
    pushExp(1, 20, 0, 0, 4'b0000); applyStimulus(1, 20, 0, 4'b0000, 4'b0000, 1);
    pushExp(1, 19, 0, 0, 4'b0000); idleStep(4'b0000);
    pushExp(0, 18, 1, 3, 4'b0010); applyStimulus(0, 0, 1, 4'b0010, 4'b0000, 1);
    pushExp(0, 18, 0, 3, 4'b0000); applyStimulus(0, 0, 0, 4'b0000, 4'b0010, 1);
    // Clear and a new set in the same cycle: set wins
    pushExp(1, 5, 0, 0, 4'b0000);  applyStimulus(1, 5, 0, 4'b0000, 4'b0000, 1);
    pushExp(0, 4, 1, 2, 4'b0010);  applyStimulus(0, 0, 0, 4'b0010, 4'b0010, 1);
    pushExp(0, 4, 0, 2, 4'b0010);  idleStep(4'b0010);

    // Zero budget: no gated cycle, done pulse, budget cause
    pushExp(0, 4, 1, 1, 4'b0010);  applyStimulus(1, 0, 0, 4'b0000, 4'b0000, 1);
    pushExp(0, 4, 0, 1, 4'b0010);  idleStep(4'b0000);
    // go together with stop: nothing starts
    pushExp(0, 4, 0, 1, 4'b0010);  applyStimulus(1, 3, 1, 4'b0000, 4'b0000, 1);

    // go during RUN is ignored
    pushExp(1, 6, 0, 0, 4'b0010);  applyStimulus(1, 6, 0, 4'b0000, 4'b0000, 1);
    pushExp(1, 5, 0, 0, 4'b0010);  applyStimulus(1, 50, 0, 4'b0000, 4'b0000, 1);
    for (int r = 4; r >= 1; r--) begin
      pushExp(1, 32'(r), 0, 0, 4'b0010); idleStep(4'b0000);
    end
    pushExp(0, 0, 1, 1, 4'b0010);  idleStep(4'b0000);
    // stop in IDLE is ignored
    pushExp(0, 0, 0, 1, 4'b0010);  applyStimulus(0, 0, 1, 4'b0000, 4'b0000, 1);

    // Reset at gated cycle 4 of a 100-cycle run
    pushExp(1, 100, 0, 0, 4'b0010); applyStimulus(1, 100, 0, 4'b0000, 4'b0000, 1);
    pushExp(1, 99, 0, 0, 4'b0010);  idleStep(4'b0000);
    pushExp(1, 98, 0, 0, 4'b0010);  idleStep(4'b0000);
    pushExp(1, 97, 0, 0, 4'b0010);  idleStep(4'b0000);
    pushExp(0, 0, 0, 0, 4'b0000);   applyStimulus(0, 0, 0, 4'b0000, 4'b0000, 0);
    pushExp(0, 0, 0, 0, 4'b0000);   idleStep(4'b0000);

    // Every pushed expectation must have been consumed
    vectors++;
    assert (expQ.size() === 0) else begin
      miscompares++;
      $error("[TB] FAIL scoreboard_drain observed=%0d expected=0", expQ.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
